count_monitor: RTL and testbench

Synchronous monitor placed directly downstream of the 3-bit ripple up counter. It samples the counter's asynchronous outputs `{qc,qb,qa}` on the system clock and rejects ripple transients with a stability filter. It checks that every accepted value is the previous value +1 mod 8, and reports the filtered count, a wrap count and a sticky sequence error. Downstream logic reads `count_out`/`count_valid` instead of the raw ripple bits.

---
 rtl/count_mon_pkg.sv | 8 +
 rtl/count_sync_filter.sv | 46 ++++
 rtl/count_monitor.sv | 61 ++++++
 tb/tb_count_monitor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared width, FSM states and sizing helper for count_monitor
package count_mon_pkg;
  localparam int CNT_W = 3;
  typedef enum logic {ST_UNLOCKED, ST_TRACK} mon_state_t;
  function automatic int stab_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/count_sync_filter.sv
// count_sync_filter: synchronizes the ripple bits and accepts values stable for STABLE_CYCLES samples
module count_sync_filter
  import count_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CNT_W-1:0] raw,
  input  logic [CNT_W-1:0] cur,
  input  logic             unlocked,
  output logic             accept,
  output logic [CNT_W-1:0] val
);
  localparam int SW = stab_w(STABLE_CYCLES);
  localparam logic [SW-1:0] SC = SW'(STABLE_CYCLES);
  logic [CNT_W-1:0] s1, s2, cand;
  logic [SW-1:0] stab, stab_d;
  logic [1:0] fill;
  // two-flop synchronizer; fill marks when s2 holds a real sample rather than reset zeros
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      s1 <= '0;
      s2 <= '0;
      fill <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      fill <= {fill[0], 1'b1};
    end
  // stability count for the next edge; acceptance is decided on the edge that reaches STABLE_CYCLES
  always_comb begin
    stab_d = !fill[1] ? '0 : s2 != cand ? SW'(1) : stab == SC ? stab : stab + SW'(1);
    accept = stab_d == SC && (unlocked || s2 != cur);
    val = s2;
  end
  // candidate value and its run length
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cand <= '0;
      stab <= '0;
    end else begin
      cand <= s2;
      stab <= stab_d;
    end
endmodule

// File: rtl/count_monitor.sv
// count_monitor: filtered view of a 3-bit ripple counter with sequence checking and wrap counting
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              qa,
  input  logic              qb,
  input  logic              qc,
  input  logic              clear_err,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_valid,
  output logic              locked,
  output logic [WRAP_W-1:0] wraps,
  output logic              err,
  output logic [CNT_W-1:0]  err_val
);
  mon_state_t state_q, state_d;
  logic accept, seq_ok, bad, wrap_inc;
  logic [CNT_W-1:0] val;
  count_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk      (clk),
    .clr      (clr),
    .raw      ({qc, qb, qa}),
    .cur      (count_out),
    .unlocked (state_q == ST_UNLOCKED),
    .accept   (accept),
    .val      (val)
  );
  // state register
  always_ff @(posedge clk or negedge clr)
    if (!clr) state_q <= ST_UNLOCKED;
    else state_q <= state_d;
  // lock on the first accepted value
  always_comb state_d = state_q == ST_UNLOCKED && accept ? ST_TRACK : state_q;
  // sequence check against the previous accepted value
  always_comb begin
    seq_ok = val == count_out + CNT_W'(1);
    bad = accept && state_q == ST_TRACK && !seq_ok;
    wrap_inc = accept && state_q == ST_TRACK && seq_ok && &count_out && !(&wraps);
    locked = state_q == ST_TRACK;
  end
  // accepted value, wrap count and sticky error; a new error beats a clear request
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      count_out <= '0;
      count_valid <= 1'b0;
      wraps <= '0;
      err <= 1'b0;
      err_val <= '0;
    end else begin
      count_out <= accept ? val : count_out;
      count_valid <= accept;
      wraps <= wrap_inc ? wraps + WRAP_W'(1) : wraps;
      err <= bad ? 1'b1 : clear_err ? 1'b0 : err;
      err_val <= bad ? val : clear_err ? '0 : err_val;
    end
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: vector table, corner sequences and randomized run against a reference model
module tb_count_monitor;
  localparam int SC = 2;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic clear_err = 1'b0;
  logic [2:0] raw = 3'd0;
  logic [2:0] count_out, err_val, count_out2, err_val2;
  logic count_valid, locked, err, count_valid2, locked2, err2;
  logic [7:0] wraps;
  logic [1:0] wraps2;
  int total = 0, bad = 0, pulses = 0;

  always #5 clk = ~clk;

  count_monitor #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .clr(clr), .qa(raw[0]), .qb(raw[1]), .qc(raw[2]), .clear_err(clear_err),
    .count_out(count_out), .count_valid(count_valid), .locked(locked), .wraps(wraps),
    .err(err), .err_val(err_val));

  count_monitor #(.STABLE_CYCLES(SC), .WRAP_W(2)) dut2 (
    .clk(clk), .clr(clr), .qa(raw[0]), .qb(raw[1]), .qc(raw[2]), .clear_err(clear_err),
    .count_out(count_out2), .count_valid(count_valid2), .locked(locked2), .wraps(wraps2),
    .err(err2), .err_val(err_val2));

  // reference model: raw samples reach the filter two edges late; a value is accepted when the
  // last SC samples agree and it differs from the current count (or nothing is locked yet)
  logic [2:0] dq[$], hq[$];
  logic [2:0] m_cnt, m_ev;
  logic m_valid, m_lock, m_err;
  int m_wr, m_wr2;

  function automatic void m_reset();
    dq = {};
    hq = {};
    m_cnt = 0; m_ev = 0; m_valid = 0; m_lock = 0; m_err = 0; m_wr = 0; m_wr2 = 0;
  endfunction

  function automatic void m_edge();
    logic [2:0] s;
    logic acc, hit;
    if (!clr) begin
      m_reset();
      return;
    end
    acc = 0;
    hit = 0;
    dq.push_back(raw);
    if (dq.size() > 2) begin
      s = dq.pop_front();
      hq.push_back(s);
      if (hq.size() > SC) void'(hq.pop_front());
      acc = hq.size() == SC;
      foreach (hq[i]) if (hq[i] != s) acc = 0;
      if (m_lock && s == m_cnt) acc = 0;
      if (acc) begin
        if (m_lock) begin
          if (int'(s) == (int'(m_cnt) + 1) % 8) begin
            if (m_cnt == 7) begin
              m_wr = m_wr < 255 ? m_wr + 1 : m_wr;
              m_wr2 = m_wr2 < 3 ? m_wr2 + 1 : m_wr2;
            end
          end else hit = 1;
        end
        m_cnt = s;
        m_lock = 1;
      end
      if (hit) begin
        m_err = 1;
        m_ev = s;
      end
    end
    if (!hit && clear_err) begin
      m_err = 0;
      m_ev = 0;
    end
    m_valid = acc;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    if (count_valid) pulses++;
    chk("model", {count_out, count_valid, locked, wraps, err, err_val, wraps2},
        {m_cnt, m_valid, m_lock, 8'(m_wr), m_err, m_ev, 2'(m_wr2)});
  endtask

  task automatic do_reset(input logic [2:0] rv);
    clr = 0;
    raw = rv;
    clear_err = 0;
    m_reset();
    #1;
    chk("rst_zero", {count_out, count_valid, locked, wraps, err, err_val, wraps2}, 0);
    repeat (2) tick();
    clr = 1;
  endtask

  typedef struct {
    logic [2:0] raw;
    int hold;
    logic ce;
    logic [2:0] cnt;
    logic e;
    logic [2:0] ev;
    logic [7:0] wr;
  } vec_t;
  vec_t tv[$];

  initial begin
    logic [2:0] cur;
    for (int v = 0; v < 8; v++) tv.push_back('{3'(v), 8, 1'b0, 3'(v), 1'b0, 3'd0, 8'd0});
    tv.push_back('{3'd0, 8, 1'b0, 3'd0, 1'b0, 3'd0, 8'd1});
    tv.push_back('{3'd1, 8, 1'b0, 3'd1, 1'b0, 3'd0, 8'd1});
    tv.push_back('{3'd2, 8, 1'b0, 3'd2, 1'b0, 3'd0, 8'd1});
    tv.push_back('{3'd3, 8, 1'b0, 3'd3, 1'b0, 3'd0, 8'd1});
    tv.push_back('{3'd7, 1, 1'b0, 3'd3, 1'b0, 3'd0, 8'd1});
    tv.push_back('{3'd4, 8, 1'b0, 3'd4, 1'b0, 3'd0, 8'd1});
    tv.push_back('{3'd2, 8, 1'b0, 3'd2, 1'b1, 3'd2, 8'd1});
    tv.push_back('{3'd4, 8, 1'b0, 3'd4, 1'b1, 3'd4, 8'd1});
    tv.push_back('{3'd5, 8, 1'b0, 3'd5, 1'b1, 3'd4, 8'd1});
    tv.push_back('{3'd5, 8, 1'b1, 3'd5, 1'b0, 3'd0, 8'd1});
    #2;
    do_reset(3'd5);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("lat_valid_e%0d", i), count_valid, i == 4);
    end
    chk("lat_cnt", count_out, 5);
    chk("lat_lock", locked, 1);
    chk("lat_err", err, 0);
    chk("lat_wraps", wraps, 0);
    do_reset(3'd0);
    pulses = 0;
    foreach (tv[i]) begin
      raw = tv[i].raw;
      clear_err = tv[i].ce;
      tick();
      clear_err = 0;
      repeat (tv[i].hold - 1) tick();
      chk($sformatf("vec%0d", i), {count_out, err, err_val, wraps},
          {tv[i].cnt, tv[i].e, tv[i].ev, tv[i].wr});
      if (i == 9) chk("clean_pulses", pulses, 10);
    end
    raw = 3'd7;
    repeat (3) tick();
    clear_err = 1;
    tick();
    clear_err = 0;
    chk("same_edge_err", {count_valid, err, err_val}, {1'b1, 1'b1, 3'd7});
    raw = 3'd6;
    repeat (8) tick();
    chk("pre_rst_cnt", count_out, 6);
    do_reset(3'd1);
    pulses = 0;
    repeat (8) tick();
    chk("post_rst", {pulses[3:0], count_out, locked, err, wraps}, {4'd1, 3'd1, 1'b1, 1'b0, 8'd0});
    do_reset(3'd0);
    for (int w = 0; w < 5; w++)
      for (int v = 0; v < 8; v++) begin
        raw = 3'(v);
        repeat (5) tick();
      end
    raw = 3'd0;
    repeat (5) tick();
    chk("wraps8", wraps, 5);
    chk("wraps2_sat", wraps2, 3);
    chk("wraps_err", err, 0);
    do_reset(3'($urandom_range(0, 7)));
    cur = raw;
    repeat (250) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(3'($urandom_range(0, 7)));
        cur = raw;
      end
      if (r >= 2 && r < 12) begin
        raw = 3'($urandom_range(0, 7));
        tick();
      end
      cur = (r >= 12 && r < 20) ? 3'($urandom_range(0, 7)) : cur + 3'd1;
      raw = cur;
      clear_err = $urandom_range(0, 19) == 0;
      tick();
      clear_err = 0;
      repeat ($urandom_range(3, 9)) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
